// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 8x8 unsigned multiply / 8/8 unsigned divide sequencer driving a shared 8-bit ALU.
// Optional macro ALU_SEQ_BYPASS_EN lets the CPU datapath drive the ALU through ext_* outside EXEC.
module alu_muldiv_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEPS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             dz_err,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_s0,
  output logic             alu_s1,
  output logic             alu_s2,
  output logic             alu_s3,
  output logic             alu_s4,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_carry
`ifdef ALU_SEQ_BYPASS_EN
  ,
  input  logic [7:0]       ext_a,
  input  logic [7:0]       ext_b,
  input  logic [4:0]       ext_s
`endif
);

  if (WIDTH != 8 || STEPS != WIDTH) begin : gen_param_check
    $error("alu_muldiv_seq supports only WIDTH = STEPS = 8");
  end

  localparam int unsigned CntW = $clog2(STEPS);
  localparam logic [CntW-1:0] LastStep = CntW'(STEPS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic             op_q, op_d;
  // p: product high / remainder; l: multiplier / quotient; m: multiplicand / divisor
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] l_q, l_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] seq_a;
  logic [WIDTH-1:0] seq_b;
  logic [4:0]       seq_s;
  logic             div_t;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    p_d     = p_q;
    l_d     = l_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    seq_a   = '0;
    seq_b   = '0;
    seq_s   = 5'b00000;
    div_t   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d  = op;
          cnt_d = '0;
          p_d   = '0;
          if (op && (opb == '0)) begin
            state_d = StDone;
            dz_d    = 1'b1;
            lo_d    = '1;
            hi_d    = opa;
          end else begin
            state_d = StExec;
            dz_d    = 1'b0;
            if (op) begin
              l_d = opa;
              m_d = opb;
            end else begin
              l_d = opb;
              m_d = opa;
            end
          end
        end
      end

      StExec: begin
        cnt_d = cnt_q + 1'b1;
        if (!op_q) begin
          // Add M when the multiplier LSB is set, otherwise add zero (s4 forces b to 0).
          seq_a    = p_q;
          seq_b    = m_q;
          seq_s[4] = ~l_q[0];
          p_d      = {alu_carry, alu_z[WIDTH-1:1]};
          l_d      = {alu_z[0], l_q[WIDTH-1:1]};
        end else begin
          div_t    = p_q[WIDTH-1];
          seq_a    = {p_q[WIDTH-2:0], l_q[WIDTH-1]};
          seq_b    = m_q;
          seq_s[3] = 1'b1;
          seq_s[2] = 1'b1;
          // A set bit shifted out of R means the shifted remainder already exceeds D.
          if (div_t || alu_carry) begin
            p_d = alu_z;
            l_d = {l_q[WIDTH-2:0], 1'b1};
          end else begin
            p_d = {p_q[WIDTH-2:0], l_q[WIDTH-1]};
            l_d = {l_q[WIDTH-2:0], 1'b0};
          end
        end
        if (cnt_q == LastStep) begin
          state_d = StDone;
          hi_d    = p_d;
          lo_d    = l_d;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= 1'b0;
      p_q     <= '0;
      l_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      p_q     <= p_d;
      l_q     <= l_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    if (state_q == StExec) begin
      alu_a = seq_a;
      alu_b = seq_b;
      {alu_s4, alu_s3, alu_s2, alu_s1, alu_s0} = seq_s;
    end else begin
`ifdef ALU_SEQ_BYPASS_EN
      alu_a = ext_a;
      alu_b = ext_b;
      {alu_s4, alu_s3, alu_s2, alu_s1, alu_s0} = ext_s;
`else
      alu_a = '0;
      alu_b = '0;
      {alu_s4, alu_s3, alu_s2, alu_s1, alu_s0} = 5'b00000;
`endif
    end
  end

  assign busy      = (state_q == StExec);
  assign done      = (state_q == StDone);
  assign dz_err    = dz_q;
  assign result_hi = hi_q;
  assign result_lo = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed self-checking bench for alu_muldiv_seq with a behavioural model of the shared ALU.
module tb_alu_muldiv_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       op;
  logic [7:0] opa;
  logic [7:0] opb;
  logic       busy;
  logic       done;
  logic       dz_err;
  logic [7:0] result_hi;
  logic [7:0] result_lo;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_s0, alu_s1, alu_s2, alu_s3, alu_s4;
  logic [7:0] alu_z;
  logic       alu_carry;
`ifdef ALU_SEQ_BYPASS_EN
  logic [7:0] ext_a;
  logic [7:0] ext_b;
  logic [4:0] ext_s;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .busy      (busy),
    .done      (done),
    .dz_err    (dz_err),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s0    (alu_s0),
    .alu_s1    (alu_s1),
    .alu_s2    (alu_s2),
    .alu_s3    (alu_s3),
    .alu_s4    (alu_s4),
    .alu_z     (alu_z),
    .alu_carry (alu_carry)
`ifdef ALU_SEQ_BYPASS_EN
    ,
    .ext_a     (ext_a),
    .ext_b     (ext_b),
    .ext_s     (ext_s)
`endif
  );

  // Shared ALU, adder path only: b may be zeroed (s4) or inverted (s3), s2 is carry-in.
  logic [7:0] alu_bm;
  always_comb begin
    alu_bm = alu_s4 ? 8'h00 : (alu_s3 ? ~alu_b : alu_b);
    {alu_carry, alu_z} = {1'b0, alu_a} + {1'b0, alu_bm} + {8'h00, alu_s2};
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_lines();
    return {3'b000, alu_s4, alu_s3, alu_s2, alu_s1, alu_s0};
  endfunction

  // Launch one operation and follow it to done; poke_at >= 0 injects a stray start during EXEC.
  task automatic run_op(input string tag, input logic o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_hi, input logic [7:0] exp_lo, input logic exp_dz,
                        input int exp_lat, input int poke_at);
    int k;
    int busy_cnt;
    logic found;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    k        = 0;
    busy_cnt = 0;
    found    = 1'b0;
    while (k < 20) begin
      if (busy) busy_cnt++;
      if (done) begin
        found = 1'b1;
        break;
      end
      if (k == poke_at) begin
        start = 1'b1;
        op    = ~o;
        opa   = 8'h33;
        opb   = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 16'(found), 16'd1);
    check({tag, "_latency"}, 16'(k), 16'(exp_lat));
    check({tag, "_busy_cycles"}, 16'(busy_cnt), 16'(exp_lat == 0 ? 0 : 8));
    check({tag, "_result"}, {result_hi, result_lo}, {exp_hi, exp_lo});
    check({tag, "_dz_err"}, 16'(dz_err), 16'(exp_dz));
    @(posedge clk);
    #1;
    check({tag, "_done_single"}, 16'(done), 16'd0);
    check({tag, "_result_hold"}, {result_hi, result_lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    int ndone;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    opa   = 8'h00;
    opb   = 8'h00;
`ifdef ALU_SEQ_BYPASS_EN
    ext_a = 8'h00;
    ext_b = 8'h00;
    ext_s = 5'b00000;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_dz", 16'(dz_err), 16'd0);
    check("rst_result", {result_hi, result_lo}, 16'h0000);
    check("rst_alu_ab", {alu_a, alu_b}, 16'h0000);
    check("rst_alu_s", alu_lines(), 16'h0000);
    reset = 1'b0;

    // MUL ff*ff: first two steps' ALU drive (P=0,M=ff, then P=7f), then the full run.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    opa   = 8'hFF;
    opb   = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("mul_step0_ab", {alu_a, alu_b}, 16'h00FF);
    check("mul_step0_s", alu_lines(), 16'h0000);
    @(posedge clk);
    #1;
    check("mul_step1_ab", {alu_a, alu_b}, 16'h7FFF);
    repeat (8) @(posedge clk);
    #1;
    check("mul_ff_idle_alu", {alu_a, alu_b}, 16'h0000);

    run_op("mul_ffxff", 1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 8, -1);
    run_op("mul_0dx0b", 1'b0, 8'h0D, 8'h0B, 8'h00, 8'h8F, 1'b0, 8, -1);
    run_op("mul_00xa5", 1'b0, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b0, 8, -1);
    run_op("mul_80x02", 1'b0, 8'h80, 8'h02, 8'h01, 8'h00, 1'b0, 8, -1);
    run_op("div_c8d07", 1'b1, 8'hC8, 8'h07, 8'h04, 8'h1C, 1'b0, 8, -1);
    run_op("div_ffd01", 1'b1, 8'hFF, 8'h01, 8'h00, 8'hFF, 1'b0, 8, -1);
    run_op("div_10d20", 1'b1, 8'h10, 8'h20, 8'h10, 8'h00, 1'b0, 8, -1);
    run_op("div_55d00", 1'b1, 8'h55, 8'h00, 8'h55, 8'hFF, 1'b1, 0, -1);
    run_op("mul_poke", 1'b0, 8'h0D, 8'h0B, 8'h00, 8'h8F, 1'b0, 8, 3);
    check("poke_idle_busy", 16'(busy), 16'd0);

    // First DIV step drives a={R[6:0],Q[7]}=01, b=D, subtract mode.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    opa   = 8'hC8;
    opb   = 8'h07;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("div_step0_ab", {alu_a, alu_b}, 16'h0107);
    check("div_step0_s", alu_lines(), 16'h000C);
    repeat (10) @(posedge clk);
    #1;
    check("div_again_result", {result_hi, result_lo}, 16'h041C);

    // Reset after four MUL steps must abort with everything cleared and no done.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    opa   = 8'hFF;
    opb   = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_busy_before", 16'(busy), 16'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    check("abort_result", {result_hi, result_lo}, 16'h0000);
    check("abort_dz", 16'(dz_err), 16'd0);
    check("abort_alu_ab", {alu_a, alu_b}, 16'h0000);
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    check("abort_no_done", 16'(ndone), 16'd0);

`ifdef ALU_SEQ_BYPASS_EN
    ext_a = 8'h5A;
    ext_b = 8'hA5;
    ext_s = 5'b10110;
    #1;
    check("byp_idle_ab", {alu_a, alu_b}, 16'h5AA5);
    check("byp_idle_s", alu_lines(), 16'h0016);
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    opa   = 8'hFF;
    opb   = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("byp_exec_ab", {alu_a, alu_b}, 16'h00FF);
    check("byp_exec_s", alu_lines(), 16'h0000);
    repeat (8) @(posedge clk);
    #1;
    check("byp_done", 16'(done), 16'd1);
    check("byp_result", {result_hi, result_lo}, 16'hFE01);
    check("byp_done_ab", {alu_a, alu_b}, 16'h5AA5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
